// File: rtl/inst_buf_queue.sv
// inst_buf_queue
//   Circular instruction buffer sitting between decode and the InstBuf->Rename
//   pipeline register. Up to DISPATCH_WIDTH decoded packets are accepted per
//   cycle and compacted in program order. The oldest DISPATCH_WIDTH entries are
//   presented as a rename bundle. Decode is back-pressured when free space
//   drops below one full bundle.
//
//   Optional feature macro: IB_PARTIAL_DISPATCH_EN
//     defined   : partial bundles are dispatched (ready when count > 0)
//     undefined : only full bundles are dispatched (ready when count >= DW)
//
// Ports
//   clk               clock, rising edge
//   reset             asynchronous active-high reset
//   flush_i           synchronous flush of all entries
//   stall_i           rename stall, blocks dequeue
//   decodeReady_i     decode bundle valid this cycle
//   decPacket_i       decode bundle, lane k = [k*PKT_W +: PKT_W]
//   decValid_i        per-lane valid of the decode bundle
//   stallFetch_o      back-pressure to decode
//   renPacket_o       oldest entries, lane 0 oldest, bit 0 = lane valid
//   renLaneValid_o    per-lane valid of the output bundle
//   instBufferReady_o output bundle valid
//   occupancy_o       current entry count
module inst_buf_queue #(
    parameter int unsigned DISPATCH_WIDTH = 4,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned PKT_W          = 128
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush_i,
    input  logic                              stall_i,
    input  logic                              decodeReady_i,
    input  logic [DISPATCH_WIDTH*PKT_W-1:0]   decPacket_i,
    input  logic [DISPATCH_WIDTH-1:0]         decValid_i,
    output logic                              stallFetch_o,
    output logic [DISPATCH_WIDTH*PKT_W-1:0]   renPacket_o,
    output logic [DISPATCH_WIDTH-1:0]         renLaneValid_o,
    output logic                              instBufferReady_o,
    output logic [$clog2(DEPTH):0]            occupancy_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PKT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [CNT_W-1:0] n_wr;
    logic [CNT_W-1:0] n_rd;
    logic [CNT_W-1:0] free_slots;
    logic [PTR_W-1:0] lane_off [DISPATCH_WIDTH];
    logic [PKT_W-1:0] rd_pkt;
    logic             enq;
    logic             deq;

    // Compaction: each valid lane lands at tail + (number of valid lanes below it).
    always_comb begin
        n_wr = '0;
        for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
            lane_off[k] = n_wr[PTR_W-1:0];
            if (decValid_i[k]) begin
                n_wr = n_wr + CNT_W'(1);
            end
        end
    end

    always_comb begin
        free_slots   = CNT_W'(DEPTH) - count;
        stallFetch_o = free_slots < CNT_W'(DISPATCH_WIDTH);
`ifdef IB_PARTIAL_DISPATCH_EN
        instBufferReady_o = count != '0;
        for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
            renLaneValid_o[k] = CNT_W'(k) < count;
        end
        n_rd = (count < CNT_W'(DISPATCH_WIDTH)) ? count : CNT_W'(DISPATCH_WIDTH);
`else
        instBufferReady_o = count >= CNT_W'(DISPATCH_WIDTH);
        renLaneValid_o    = {DISPATCH_WIDTH{instBufferReady_o}};
        n_rd              = CNT_W'(DISPATCH_WIDTH);
`endif
    end

    assign enq         = decodeReady_i & ~stallFetch_o & ~flush_i;
    assign deq         = instBufferReady_o & ~stall_i & ~flush_i;
    assign occupancy_o = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + n_wr[PTR_W-1:0];
            end
            if (deq) begin
                head <= head + n_rd[PTR_W-1:0];
            end
            count <= count + (enq ? n_wr : '0) - (deq ? n_rd : '0);
        end
    end

    // Storage is not reset; only entries between head and tail are meaningful.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
                if (decValid_i[k]) begin
                    mem[tail + lane_off[k]] <= decPacket_i[k*PKT_W +: PKT_W];
                end
            end
        end
    end

    // Output lanes read straight from storage (no same-cycle bypass); bit 0
    // carries the lane valid so stale entries never look valid downstream.
    always_comb begin
        renPacket_o = '0;
        rd_pkt      = '0;
        for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
            rd_pkt    = mem[head + PTR_W'(k)];
            rd_pkt[0] = renLaneValid_o[k];
            renPacket_o[k*PKT_W +: PKT_W] = rd_pkt;
        end
    end

endmodule

// File: tb/tb_inst_buf_queue.sv
module tb_inst_buf_queue;

    localparam int unsigned DW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PW    = 128;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush_i = 1'b0;
    logic             stall_i = 1'b0;
    logic             decodeReady_i = 1'b0;
    logic [DW*PW-1:0] decPacket_i = '0;
    logic [DW-1:0]    decValid_i = '0;
    logic             stallFetch_o;
    logic [DW*PW-1:0] renPacket_o;
    logic [DW-1:0]    renLaneValid_o;
    logic             instBufferReady_o;
    logic [4:0]       occupancy_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned exp_q[$];

    inst_buf_queue #(
        .DISPATCH_WIDTH(DW),
        .DEPTH(DEPTH),
        .PKT_W(PW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush_i(flush_i),
        .stall_i(stall_i),
        .decodeReady_i(decodeReady_i),
        .decPacket_i(decPacket_i),
        .decValid_i(decValid_i),
        .stallFetch_o(stallFetch_o),
        .renPacket_o(renPacket_o),
        .renLaneValid_o(renLaneValid_o),
        .instBufferReady_o(instBufferReady_o),
        .occupancy_o(occupancy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mk(input int unsigned id);
        logic [PW-1:0] p;
        p    = {4{id + 32'h1000_0000}};
        p[0] = 1'b1;
        return p;
    endfunction

    function automatic logic [PW-1:0] lane_of(input logic [DW*PW-1:0] v, input int unsigned k);
        return v[k*PW +: PW];
    endfunction

    function automatic logic [DW-1:0] bit0s(input logic [DW*PW-1:0] v);
        logic [DW-1:0] b;
        for (int unsigned k = 0; k < DW; k++) b[k] = v[k*PW];
        return b;
    endfunction

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int unsigned k, input logic [PW-1:0] p);
        decPacket_i[k*PW +: PW] = p;
    endtask

    task automatic drive_full(input int unsigned base);
        for (int unsigned k = 0; k < DW; k++) set_lane(k, mk(base + k));
        decValid_i    = '1;
        decodeReady_i = 1'b1;
    endtask

    task automatic idle();
        decodeReady_i = 1'b0;
        decValid_i    = '0;
    endtask

    task automatic do_reset();
        idle();
        flush_i = 1'b0;
        stall_i = 1'b0;
        reset   = 1'b1;
        step();
        reset   = 1'b0;
    endtask

    initial begin
        // reset state and compaction of 4'b1011
        do_reset();
        check("rst_occ",  PW'(occupancy_o), PW'(0));
        check("rst_rdy",  PW'(instBufferReady_o), PW'(0));
        check("rst_lv",   PW'(renLaneValid_o), PW'(0));
        check("rst_stf",  PW'(stallFetch_o), PW'(0));
        check("rst_bit0", PW'(bit0s(renPacket_o)), PW'(0));

        set_lane(0, mk(1));
        set_lane(1, mk(2));
        set_lane(2, mk(99));
        set_lane(3, mk(4));
        decValid_i    = 4'b1011;
        decodeReady_i = 1'b1;
        step();
        idle();
        check("cmp_occ", PW'(occupancy_o), PW'(3));
        check("cmp_l0", lane_of(renPacket_o, 0) >> 1, mk(1) >> 1);
        check("cmp_l1", lane_of(renPacket_o, 1) >> 1, mk(2) >> 1);
        check("cmp_l2", lane_of(renPacket_o, 2) >> 1, mk(4) >> 1);
`ifdef IB_PARTIAL_DISPATCH_EN
        check("cmp_rdy", PW'(instBufferReady_o), PW'(1));
        check("cmp_lv",  PW'(renLaneValid_o), PW'(4'b0111));
        check("cmp_b0",  PW'(bit0s(renPacket_o)), PW'(4'b0111));
`else
        check("cmp_rdy", PW'(instBufferReady_o), PW'(0));
        check("cmp_lv",  PW'(renLaneValid_o), PW'(0));
        check("cmp_b0",  PW'(bit0s(renPacket_o)), PW'(0));
`endif

        // fill to full under stall, fifth bundle ignored
        do_reset();
        stall_i = 1'b1;
        for (int unsigned b = 0; b < 4; b++) begin
            drive_full(10 + 4*b);
            step();
            check("fill_occ", PW'(occupancy_o), PW'(4*(b+1)));
            check("fill_stf", PW'(stallFetch_o), PW'(b == 3 ? 1 : 0));
        end
        drive_full(50);
        step();
        idle();
        check("full_occ", PW'(occupancy_o), PW'(16));
        check("full_stf", PW'(stallFetch_o), PW'(1));
        check("full_rdy", PW'(instBufferReady_o), PW'(1));
        check("full_lv",  PW'(renLaneValid_o), PW'(4'b1111));
        for (int unsigned k = 0; k < DW; k++)
            check("full_lane", lane_of(renPacket_o, k), mk(10 + k));

        // stall hold from count 12
        do_reset();
        stall_i = 1'b1;
        for (int unsigned b = 0; b < 3; b++) begin
            drive_full(100 + 4*b);
            step();
        end
        check("hold_occ12", PW'(occupancy_o), PW'(12));
        check("hold_stf12", PW'(stallFetch_o), PW'(0));
        for (int unsigned c = 0; c < 3; c++) begin
            drive_full(200 + 4*c);
            step();
            check("hold_occ", PW'(occupancy_o), PW'(16));
            check("hold_stf", PW'(stallFetch_o), PW'(1));
            check("hold_l0",  lane_of(renPacket_o, 0), mk(100));
            check("hold_l3",  lane_of(renPacket_o, 3), mk(103));
        end
        idle();

        // concurrent dequeue/enqueue across the 15->0 wrap
        do_reset();
        stall_i = 1'b1;
        exp_q.delete();
        for (int unsigned b = 0; b < 2; b++) begin
            drive_full(300 + 4*b);
            step();
            for (int unsigned k = 0; k < DW; k++) exp_q.push_back(300 + 4*b + k);
        end
        stall_i = 1'b0;
        for (int unsigned c = 0; c < 10; c++) begin
            drive_full(400 + 4*c);
            for (int unsigned k = 0; k < DW; k++)
                check("wrap_lane", lane_of(renPacket_o, k), mk(exp_q[k]));
            step();
            for (int unsigned k = 0; k < DW; k++) begin
                void'(exp_q.pop_front());
                exp_q.push_back(400 + 4*c + k);
            end
            check("wrap_occ", PW'(occupancy_o), PW'(8));
        end

        // flush with simultaneous enqueue and dequeue
        flush_i = 1'b1;
        drive_full(600);
        step();
        flush_i = 1'b0;
        idle();
        check("fl_occ", PW'(occupancy_o), PW'(0));
        check("fl_rdy", PW'(instBufferReady_o), PW'(0));
        check("fl_lv",  PW'(renLaneValid_o), PW'(0));
        stall_i = 1'b1;
        drive_full(700);
        step();
        idle();
        check("fl_post_occ", PW'(occupancy_o), PW'(4));
        check("fl_post_l0",  lane_of(renPacket_o, 0), mk(700));

        // asynchronous reset between edges with count 6
        do_reset();
        stall_i = 1'b1;
        drive_full(800);
        step();
        set_lane(0, mk(804));
        set_lane(1, mk(805));
        decValid_i = 4'b0011;
        step();
        idle();
        check("ar_pre_occ", PW'(occupancy_o), PW'(6));
        check("ar_pre_rdy", PW'(instBufferReady_o), PW'(1));
        #3;
        reset = 1'b1;
        #1;
        check("ar_occ",  PW'(occupancy_o), PW'(0));
        check("ar_rdy",  PW'(instBufferReady_o), PW'(0));
        check("ar_lv",   PW'(renLaneValid_o), PW'(0));
        check("ar_stf",  PW'(stallFetch_o), PW'(0));
        check("ar_bit0", PW'(bit0s(renPacket_o)), PW'(0));
        #1;
        reset   = 1'b0;
        stall_i = 1'b0;
        step();
        check("ar_post_occ", PW'(occupancy_o), PW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_buf_queue.md
# inst_buf_queue

Circular instruction buffer between the decode stage and the InstBuf→Rename pipeline register. It accepts up to `DISPATCH_WIDTH` decoded packets per cycle and compacts them in program order. It presents the oldest `DISPATCH_WIDTH` entries as a rename bundle with a ready flag, and back-pressures decode when free space is short. It is the producer side of the rename handshake: `renPacket_o` and `instBufferReady_o` feed the rename pipeline register, which samples them when not stalled.

## Interface
- `DISPATCH_WIDTH`, 4: lanes per bundle, both in and out.
- `DEPTH`, 16: entries; power of two, ≥ 2·`DISPATCH_WIDTH`.
- `PKT_W`, 128: bits per packet; bit 0 is the packet valid bit.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous and active-high.
- `flush_i`  in  1  exception/mispredict flush; synchronous.
- `stall_i`  in  1  rename stall; while high, no dequeue.
- `decodeReady_i`  in  1  the decode bundle this cycle is valid.
- `decPacket_i`  in  `DISPATCH_WIDTH`·`PKT_W`  decode bundle; lane k is bits [k·PKT_W +: PKT_W].
- `decValid_i`  in  `DISPATCH_WIDTH`  per-lane valid for the decode bundle.
- `stallFetch_o`  out  1  back-pressure to decode.
- `renPacket_o`  out  `DISPATCH_WIDTH`·`PKT_W`  oldest entries; lane 0 is the oldest.
- `renLaneValid_o`  out  `DISPATCH_WIDTH`  per-lane valid for the output bundle.
- `instBufferReady_o`  out  1  the output bundle is valid this cycle.
- `occupancy_o`  out  log2(`DEPTH`)+1  current entry count.

## Operation
- **State.** Storage array `DEPTH`×`PKT_W`, not reset. Pointers `head`/`tail` are log2(`DEPTH`) bits and wrap modulo `DEPTH`. `count` is log2(`DEPTH`)+1 bits.
- **Back-pressure.** `stallFetch_o = (DEPTH − count) < DISPATCH_WIDTH`. It is combinational from `count`.
- **Enqueue.** Condition: `decodeReady_i & ~stallFetch_o & ~flush_i`.
  - nWr = popcount(`decValid_i`).
  - Valid lanes are written in ascending lane order to `tail`, `tail`+1, … with holes squeezed out.
  - Writes wrap past `DEPTH`−1 to 0.
  - `tail` += nWr.
- **Output.** Lane k of `renPacket_o` = storage[`head`+k mod `DEPTH`].
  - Bit 0 of each output lane is forced to `renLaneValid_o[k]`.
  - The output never bypasses same-cycle input.
- **Dequeue.** Condition: `instBufferReady_o & ~stall_i & ~flush_i`.
  - `head` += nRd. nRd depends on the configuration (see Configuration).
- **Count update.** `count_next = count + nWr − nRd`. Enqueue and dequeue may occur in the same cycle.
- **Overflow.** Impossible by construction: an enqueue is accepted only when free space ≥ `DISPATCH_WIDTH`.
- **Flush.** `head`, `tail` and `count` are cleared to 0 at the next edge. Flush overrides the same-cycle enqueue and dequeue.
- **Reset.** Pointers and count go to 0 asynchronously.
  - Resulting outputs: `instBufferReady_o`=0, `renLaneValid_o`=0, `stallFetch_o`=0, `occupancy_o`=0.
  - Data bits of `renPacket_o` are undefined, except bit 0 of each lane, which is 0.

## Timing
- Write-to-visible latency is 1 cycle: a packet enqueued at edge N can appear on `renPacket_o` in the cycle after edge N.
- `instBufferReady_o`, `renLaneValid_o` and `stallFetch_o` are combinational from registered state only. There is no combinational path from `stall_i`, `decodeReady_i` or `flush_i` to any output.
- Dequeue and enqueue take effect on the same edge. A full buffer with a dequeue in progress still asserts `stallFetch_o` for that cycle (conservative).
- `stall_i` held for M cycles: `head` and outputs hold for M cycles and enqueues continue until `stallFetch_o` asserts.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.

## Configuration
- **`IB_PARTIAL_DISPATCH_EN` defined:**
  - `instBufferReady_o = count > 0`.
  - `renLaneValid_o[k] = k < count`.
  - nRd = min(count, `DISPATCH_WIDTH`).
- **Undefined (full bundles only):**
  - `instBufferReady_o = count ≥ DISPATCH_WIDTH`.
  - `renLaneValid_o` is all ones when ready, zero otherwise.
  - nRd = `DISPATCH_WIDTH`.

## Test plan
All scenarios use DW=4, DEPTH=16.
- **Reset, then compaction.** Reset, then enqueue `decValid_i`=4'b1011 with payloads A,B,–,D → `occupancy_o`=3, entries A,B,D. Ready stays 0 without the macro; with the macro ready=1 and `renLaneValid_o`=4'b0111.
- **Fill to full.** Enqueue 4 full bundles with `stall_i`=1 → `occupancy_o`=16, `stallFetch_o`=1. A fifth bundle is ignored and count stays 16.
- **Wrap-around.** Dequeue and enqueue full bundles concurrently for 10 cycles → count stays constant and the output order matches the input order across the `head`/`tail` wrap at index 15→0.
- **Flush with simultaneous traffic.** With count=8, assert `flush_i` together with an enqueue and `stall_i`=0 → count=0 at the next edge, `instBufferReady_o`=0, no entry written.
- **Stall hold.** With count=12 and `stall_i`=1 for 3 cycles → `renPacket_o` is stable, nothing is dequeued, and `stallFetch_o` asserts once count reaches 16.
- **Asynchronous reset mid-cycle.** Pulse `reset` between clock edges with count=6 → `occupancy_o`=0 and all valid outputs are 0 before the next edge.
